// File: rtl/move_scheduler_if.sv
// Direction encoding shared with direction_control, plus the scheduler's game/trail port bundle.
// master = move_scheduler side; slave = direction source / trail memory / draw path side.
package move_pkg;
  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    UP    = 3'd4
  } directions;
endpackage

interface move_scheduler_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  import move_pkg::*;

  logic          game_start;
  directions     direction_1;
  directions     direction_2;
  logic [XW-1:0] pos1_x;
  logic [YW-1:0] pos1_y;
  logic [XW-1:0] pos2_x;
  logic [YW-1:0] pos2_y;
  logic          trail_we;
  logic [XW-1:0] trail_x;
  logic [YW-1:0] trail_y;
  logic          trail_id;
  logic          step_done;
  logic          running;
  logic          game_over;
  logic [1:0]    winner;

  modport master (
    input  game_start, direction_1, direction_2,
    output pos1_x, pos1_y, pos2_x, pos2_y, trail_we, trail_x, trail_y, trail_id,
           step_done, running, game_over, winner
  );

  modport slave (
    output game_start, direction_1, direction_2,
    input  pos1_x, pos1_y, pos2_x, pos2_y, trail_we, trail_x, trail_y, trail_id,
           step_done, running, game_over, winner
  );
endinterface

// File: rtl/move_scheduler.sv
// Steps both heads once per TICK_DIV cycles, detects wall/head-on crashes and serialises trail writes P1 then P2.
// Build option WRAP_EDGES_EN: edge moves wrap around the grid instead of crashing.
module move_scheduler #(
  parameter int TICK_DIV = 1_300_000,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int P1_X0    = 8,
  parameter int P1_Y0    = 24,
  parameter int P2_X0    = 55,
  parameter int P2_Y0    = 24
) (
  input logic              clk,
  input logic              rst,
  move_scheduler_if.master bus
);
  import move_pkg::*;

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X1_START  = XW'(P1_X0);
  localparam logic [YW-1:0] Y1_START  = YW'(P1_Y0);
  localparam logic [XW-1:0] X2_START  = XW'(P2_X0);
  localparam logic [YW-1:0] Y2_START  = YW'(P2_Y0);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  // The three step cycles are credited to the next period so step_done pulses stay TICK_DIV apart.
  localparam logic [PW-1:0] STEP_CREDIT = PW'(3);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, STEP_P1, STEP_P2, CHECK, OVER} state_t;

  typedef struct packed {
    logic          crash;
    logic          moved;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } head_t;

  state_t        state, state_nxt;
  logic [PW-1:0] tick_cnt;
  logic [XW-1:0] pos1_x, pos2_x, prev1_x, prev2_x, trail_x;
  logic [YW-1:0] pos1_y, pos2_y, prev1_y, prev2_y, trail_y;
  logic          crash1, crash2, trail_we, trail_id, step_done;
  logic [1:0]    winner;
  head_t         h1, h2;
  logic          head_on, c1_any, c2_any;

  // Edge tests happen before the add/subtract, so nothing ever wraps through the unsigned range.
  function automatic head_t next_head(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                      input directions d);
    head_t h;
    h.crash = 1'b0;
    h.moved = 1'b0;
    h.x     = x;
    h.y     = y;
    case (d)
      RIGHT: begin
        if (x == X_MAX) begin
`ifdef WRAP_EDGES_EN
          h.x = '0; h.moved = 1'b1;
`else
          h.crash = 1'b1;
`endif
        end else begin
          h.x = x + XW'(1); h.moved = 1'b1;
        end
      end
      LEFT: begin
        if (x == '0) begin
`ifdef WRAP_EDGES_EN
          h.x = X_MAX; h.moved = 1'b1;
`else
          h.crash = 1'b1;
`endif
        end else begin
          h.x = x - XW'(1); h.moved = 1'b1;
        end
      end
      DOWN: begin
        if (y == Y_MAX) begin
`ifdef WRAP_EDGES_EN
          h.y = '0; h.moved = 1'b1;
`else
          h.crash = 1'b1;
`endif
        end else begin
          h.y = y + YW'(1); h.moved = 1'b1;
        end
      end
      UP: begin
        if (y == '0) begin
`ifdef WRAP_EDGES_EN
          h.y = Y_MAX; h.moved = 1'b1;
`else
          h.crash = 1'b1;
`endif
        end else begin
          h.y = y - YW'(1); h.moved = 1'b1;
        end
      end
      default: ;
    endcase
    return h;
  endfunction

  assign h1 = next_head(pos1_x, pos1_y, bus.direction_1);
  assign h2 = next_head(pos2_x, pos2_y, bus.direction_2);

  // Same cell after the step, or each head now sits where the other one started.
  assign head_on = ({pos1_x, pos1_y} == {pos2_x, pos2_y}) ||
                   (({pos1_x, pos1_y} == {prev2_x, prev2_y}) &&
                    ({pos2_x, pos2_y} == {prev1_x, prev1_y}));
  assign c1_any  = crash1 | head_on;
  assign c2_any  = crash2 | head_on;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.game_start) begin
      state_nxt = WAIT_TICK;
    end else begin
      case (state)
        WAIT_TICK: if (tick_cnt == TICK_LAST) state_nxt = STEP_P1;
        STEP_P1:   state_nxt = STEP_P2;
        STEP_P2:   state_nxt = CHECK;
        CHECK:     state_nxt = (c1_any || c2_any) ? OVER : WAIT_TICK;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.game_start) begin
      tick_cnt  <= '0;
      pos1_x    <= X1_START;
      pos1_y    <= Y1_START;
      pos2_x    <= X2_START;
      pos2_y    <= Y2_START;
      prev1_x   <= X1_START;
      prev1_y   <= Y1_START;
      prev2_x   <= X2_START;
      prev2_y   <= Y2_START;
      crash1    <= 1'b0;
      crash2    <= 1'b0;
      winner    <= 2'b00;
      trail_we  <= 1'b0;
      trail_x   <= '0;
      trail_y   <= '0;
      trail_id  <= 1'b0;
      step_done <= 1'b0;
    end else begin
      trail_we  <= 1'b0;
      step_done <= 1'b0;
      case (state)
        WAIT_TICK: tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + PW'(1);
        STEP_P1: begin
          prev1_x  <= pos1_x;
          prev1_y  <= pos1_y;
          pos1_x   <= h1.x;
          pos1_y   <= h1.y;
          crash1   <= h1.crash;
          trail_we <= h1.moved;
          trail_x  <= h1.x;
          trail_y  <= h1.y;
          trail_id <= 1'b0;
        end
        STEP_P2: begin
          prev2_x   <= pos2_x;
          prev2_y   <= pos2_y;
          pos2_x    <= h2.x;
          pos2_y    <= h2.y;
          crash2    <= h2.crash;
          trail_we  <= h2.moved;
          trail_x   <= h2.x;
          trail_y   <= h2.y;
          trail_id  <= 1'b1;
          step_done <= 1'b1;
        end
        CHECK: begin
          if (c1_any || c2_any) begin
            crash1 <= c1_any;
            crash2 <= c2_any;
            winner <= {c1_any, c2_any};
          end else begin
            tick_cnt <= STEP_CREDIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pos1_x    = pos1_x;
  assign bus.pos1_y    = pos1_y;
  assign bus.pos2_x    = pos2_x;
  assign bus.pos2_y    = pos2_y;
  assign bus.trail_we  = trail_we;
  assign bus.trail_x   = trail_x;
  assign bus.trail_y   = trail_y;
  assign bus.trail_id  = trail_id;
  assign bus.step_done = step_done;
  assign bus.running   = (state == WAIT_TICK) || (state == STEP_P1) ||
                         (state == STEP_P2) || (state == CHECK);
  assign bus.game_over = (state == OVER);
  assign bus.winner    = winner;
endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler on an 8x8 grid with TICK_DIV=4: scripted table game, corner sequences,
// and random games checked against a cell-level model of the movement and crash rules.
module tb_move_scheduler;
  import move_pkg::*;

  localparam int TD = 4, W = 8, H = 8;
  localparam int P1X = 1, P1Y = 4, P2X = 6, P2Y = 4;

  typedef struct {
    directions d1;
    directions d2;
    int p1x; int p1y; int p2x; int p2y; int win;
  } vec_t;

  typedef struct {
    int x; int y; int id; int c;
  } tw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int DX[5] = '{0, 1, 0, -1, 0};
  int DY[5] = '{0, 0, 1, 0, -1};

  int m1x, m1y, m2x, m2y, mwin, next_done;
  bit mover;

  move_scheduler_if #(.XW(3), .YW(3)) bus();

  move_scheduler #(
    .TICK_DIV(TD), .GRID_W(W), .GRID_H(H),
    .P1_X0(P1X), .P1_Y0(P1Y), .P2_X0(P2X), .P2_Y0(P2Y)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_p1x"}, int'(bus.pos1_x), m1x);
    check({tag, "_p1y"}, int'(bus.pos1_y), m1y);
    check({tag, "_p2x"}, int'(bus.pos2_x), m2x);
    check({tag, "_p2y"}, int'(bus.pos2_y), m2y);
    check({tag, "_winner"}, int'(bus.winner), mwin);
    check({tag, "_game_over"}, int'(bus.game_over), int'(mover));
    check({tag, "_running"}, int'(bus.running), int'(!mover));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p1x"}, int'(bus.pos1_x), P1X);
    check({tag, "_p1y"}, int'(bus.pos1_y), P1Y);
    check({tag, "_p2x"}, int'(bus.pos2_x), P2X);
    check({tag, "_p2y"}, int'(bus.pos2_y), P2Y);
    check({tag, "_trail_we"}, int'(bus.trail_we), 0);
    check({tag, "_step_done"}, int'(bus.step_done), 0);
    check({tag, "_running"}, int'(bus.running), 0);
    check({tag, "_game_over"}, int'(bus.game_over), 0);
    check({tag, "_winner"}, int'(bus.winner), 0);
  endtask

  task automatic model_reload();
    m1x = P1X; m1y = P1Y; m2x = P2X; m2y = P2Y;
    mwin = 0; mover = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    bus.game_start = 1'b1;
    @(negedge clk);
    bus.game_start = 1'b0;
    model_reload();
    next_done = cyc + 6;
  endtask

  // Apply one step's headings, follow the DUT to step_done and compare against the model.
  task automatic run_step(input directions d1, input directions d2);
    tw_t got[$];
    tw_t exp[$];
    int  n1x, n1y, n2x, n2y, dn;
    bit  c1, c2, mv1, mv2, head, seen;
    bus.direction_1 = d1;
    bus.direction_2 = d2;

    n1x = m1x + DX[int'(d1)]; n1y = m1y + DY[int'(d1)];
    n2x = m2x + DX[int'(d2)]; n2y = m2y + DY[int'(d2)];
    c1 = (n1x < 0) || (n1x >= W) || (n1y < 0) || (n1y >= H);
    c2 = (n2x < 0) || (n2x >= W) || (n2y < 0) || (n2y >= H);
`ifdef WRAP_EDGES_EN
    if (c1) begin n1x = (n1x + W) % W; n1y = (n1y + H) % H; c1 = 1'b0; end
    if (c2) begin n2x = (n2x + W) % W; n2y = (n2y + H) % H; c2 = 1'b0; end
`else
    if (c1) begin n1x = m1x; n1y = m1y; end
    if (c2) begin n2x = m2x; n2y = m2y; end
`endif
    mv1  = !c1 && (d1 != WAIT);
    mv2  = !c2 && (d2 != WAIT);
    head = (n1x == n2x && n1y == n2y) ||
           (n1x == m2x && n1y == m2y && n2x == m1x && n2y == m1y);

    seen = 1'b0;
    dn   = 0;
    for (int i = 0; i < 3 * TD + 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.trail_we)
        got.push_back('{int'(bus.trail_x), int'(bus.trail_y), int'(bus.trail_id), cyc});
      if (bus.step_done) begin
        seen = 1'b1;
        dn   = cyc;
      end
    end
    check("step_done_seen", int'(seen), 1);
    if (!seen) return;
    check("step_done_cycle", dn, next_done);

    if (mv1) exp.push_back('{n1x, n1y, 0, dn - 1});
    if (mv2) exp.push_back('{n2x, n2y, 1, dn});
    check("trail_count", got.size(), exp.size());
    for (int k = 0; k < got.size() && k < exp.size(); k++) begin
      check("trail_x", got[k].x, exp[k].x);
      check("trail_y", got[k].y, exp[k].y);
      check("trail_id", got[k].id, exp[k].id);
      check("trail_cycle", got[k].c, exp[k].c);
    end

    m1x = n1x; m1y = n1y; m2x = n2x; m2y = n2y;
    if (head) begin c1 = 1'b1; c2 = 1'b1; end
    if (c1 || c2) begin
      mover = 1'b1;
      mwin  = (c1 ? 2 : 0) + (c2 ? 1 : 0);
    end
    next_done = dn + TD;
    @(negedge clk);
    check_model("step");
  endtask

  initial begin
    vec_t tbl[9];
    int   sd;
    bit   found;

    tbl[0] = '{WAIT,  WAIT, 1, 4, 6, 4, 0};
    tbl[1] = '{WAIT,  WAIT, 1, 4, 6, 4, 0};
    tbl[2] = '{WAIT,  WAIT, 1, 4, 6, 4, 0};
    tbl[3] = '{RIGHT, LEFT, 2, 4, 5, 4, 0};
    tbl[4] = '{UP,    DOWN, 2, 3, 5, 5, 0};
    tbl[5] = '{UP,    DOWN, 2, 2, 5, 6, 0};
    tbl[6] = '{UP,    DOWN, 2, 1, 5, 7, 0};
    tbl[7] = '{UP,    WAIT, 2, 0, 5, 7, 0};
`ifdef WRAP_EDGES_EN
    tbl[8] = '{UP,    WAIT, 2, 7, 5, 7, 0};
`else
    tbl[8] = '{UP,    WAIT, 2, 0, 5, 7, 2};
`endif

    bus.game_start  = 1'b0;
    bus.direction_1 = WAIT;
    bus.direction_2 = WAIT;
    model_reload();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Scripted game: idle steps, opposing moves, then P1 runs into the top wall.
    start_game();
    for (int i = 0; i < 9; i++) begin
      run_step(tbl[i].d1, tbl[i].d2);
      check("tbl_p1x", int'(bus.pos1_x), tbl[i].p1x);
      check("tbl_p1y", int'(bus.pos1_y), tbl[i].p1y);
      check("tbl_p2x", int'(bus.pos2_x), tbl[i].p2x);
      check("tbl_p2y", int'(bus.pos2_y), tbl[i].p2y);
      check("tbl_winner", int'(bus.winner), tbl[i].win);
    end

    if (mover) begin
      sd = 0;
      repeat (10) begin
        @(negedge clk);
        sd += int'(bus.step_done) + int'(bus.trail_we);
      end
      check("over_quiet", sd, 0);
      check_model("over_hold");
    end

    // Restart from OVER (or from running under wrap).
    start_game();
    check_model("restart");
    check("restart_running", int'(bus.running), 1);

    // Swap cells head-on.
    start_game();
    run_step(RIGHT, LEFT);
    run_step(RIGHT, LEFT);
    run_step(RIGHT, LEFT);
    check("swap_winner", int'(bus.winner), 3);
    check("swap_over", int'(bus.game_over), 1);

    // Meet in the same cell.
    start_game();
    run_step(RIGHT, LEFT);
    run_step(WAIT, LEFT);
    run_step(RIGHT, LEFT);
    check("meet_winner", int'(bus.winner), 3);
    check("meet_p1x", int'(bus.pos1_x), 3);
    check("meet_p2x", int'(bus.pos2_x), 3);

    // game_start arriving in STEP_P1 drops the pending write and reloads.
    start_game();
    run_step(RIGHT, LEFT);
    start_game();
    check("midrun_trail_dropped", int'(bus.trail_we), 0);
    check_model("midrun_restart");
    run_step(WAIT, WAIT);

    // Reset asserted while P1's trail write is on the bus (STEP_P2).
    start_game();
    bus.direction_1 = RIGHT;
    bus.direction_2 = WAIT;
    found = 1'b0;
    for (int i = 0; i < 3 * TD + 8 && !found; i++) begin
      @(negedge clk);
      if (bus.trail_we && !bus.trail_id) found = 1'b1;
    end
    check("p2_phase_found", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midstep_reset");
    sd = 0;
    repeat (10) begin
      @(negedge clk);
      sd += int'(bus.running) + int'(bus.step_done) + int'(bus.trail_we);
    end
    check("idle_hold", sd, 0);

    // Random games against the model.
    for (int g = 0; g < 6; g++) begin
      start_game();
      for (int s = 0; s < 25 && !mover; s++)
        run_step(directions'(3'($urandom_range(0, 4))), directions'(3'($urandom_range(0, 4))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sequences per-step movement of both players from their current `directions` values.
- Owns the step prescaler, both head positions, wall and head-on crash detection, and the game run/over state.
- Time-shares the single trail-RAM write port between player 1 and player 2, in fixed order, one write per cycle.
- Sits between direction_control (direction_1/direction_2 inputs) and the trail memory / draw path.

Parameters:
- TICK_DIV, 1_300_000, clock cycles per movement step (≥4).
- GRID_W, 64, grid columns; x range 0..GRID_W-1.
- GRID_H, 48, grid rows; y range 0..GRID_H-1.
- P1_X0, 8, player 1 start x. P1_Y0, 24, player 1 start y.
- P2_X0, 55, player 2 start x. P2_Y0, 24, player 2 start y.
- XW = $clog2(GRID_W), YW = $clog2(GRID_H) (localparams).

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset, synchronous, active-high.
- game_start  in  1  single-cycle pulse; starts or restarts a game.
- direction_1  in  directions  player 1 heading (WAIT/RIGHT/DOWN/LEFT/UP).
- direction_2  in  directions  player 2 heading.
- pos1_x / pos1_y  out  XW / YW  player 1 head.
- pos2_x / pos2_y  out  XW / YW  player 2 head.
- trail_we  out  1  trail RAM write strobe.
- trail_x / trail_y  out  XW / YW  trail write cell.
- trail_id  out  1  0 = player 1, 1 = player 2.
- step_done  out  1  1-cycle pulse at end of each evaluated step.
- running  out  1  high in WAIT_TICK/STEP_P1/STEP_P2/CHECK.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw.

Behaviour:
- Reset values: FSM=IDLE; positions = P1/P2 start; prescaler=0; trail_we=0; step_done=0; game_over=0; winner=00; crash flags=0.
- FSM states: IDLE, WAIT_TICK, STEP_P1, STEP_P2, CHECK, OVER.
- IDLE→WAIT_TICK on game_start. Positions load start values; prescaler=0; winner=00.
- Prescaler counts only in WAIT_TICK. At TICK_DIV-1: go to STEP_P1, prescaler←0.
- STEP_P1 computes the next head from direction_1:
  - RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1, WAIT no move.
  - If the move would leave 0..GRID_W-1 / 0..GRID_H-1: set crash1; position unchanged.
  - Otherwise update pos1 at the clock edge.
- STEP_P2: same for player 2 / crash2.
  - Uses the pre-step pos2 values and the already-updated pos1 (head-on check is in CHECK).
- Unsigned arithmetic. Edge tests compare against 0 and GRID-1 before add/subtract; no underflow wrap reaches position registers.
- Trail writes are registered, one per cycle, fixed order P1 then P2:
  - trail_we=1 during the STEP_P2 cycle with the new pos1 (trail_id=0), if P1 moved.
  - trail_we=1 during the CHECK cycle with the new pos2 (trail_id=1), if P2 moved.
  - No write for a WAIT player or a crashed player.
- CHECK:
  - step_done=1.
  - Head-on: new pos1==new pos2, or the two players swapped cells. Sets both crash flags.
  - Any crash → OVER with winner {crash1,crash2} mapped: crash2 only→01, crash1 only→10, both→11.
  - Otherwise → WAIT_TICK.
- Step latency: 3 cycles from prescaler terminal count to step_done; TICK_DIV cycles between successive step_done pulses.
- OVER: positions, winner and game_over held. game_start → WAIT_TICK with full reload (same as from IDLE).
- game_start in any running state restarts: reload positions, clear winner/crash flags, prescaler=0, any pending trail write dropped.
- Direction inputs are sampled only in STEP_P1/STEP_P2; changes between steps have no effect until the next step.
- rst in any state returns to reset values on the next edge, including mid-step; no partial trail write after reset.

Optional Feature:
- Macro WRAP_EDGES_EN.
- Defined: edge moves wrap (x GRID_W-1→0, 0→GRID_W-1; same for y); wall crashes never occur; only head-on ends the game.
- Undefined: wall crash behaviour as above.

Test Plan:
All with TICK_DIV=4, GRID_W=8, GRID_H=8, P1=(1,4), P2=(6,4).
- Reset, game_start, both WAIT for 3 ticks → positions stay (1,4)/(6,4); no trail_we; step_done every 4 cycles.
- direction_1=RIGHT, direction_2=LEFT, one tick → pos1=(2,4), pos2=(5,4). trail_we seq (2,4,id0) then (5,4,id1) on consecutive cycles; step_done 3 cycles after terminal count.
- direction_1=UP from (1,0) → crash1; winner=10, game_over=1, pos1 stays (1,0), no P1 write. With WRAP_EDGES_EN: pos1=(1,7), game continues.
- P1 at (3,4) RIGHT, P2 at (4,4) LEFT (swap) → winner=11. P1 (2,4) RIGHT, P2 (4,4) LEFT (meet at (3,4)) → winner=11.
- In OVER, pulse game_start → positions (1,4)/(6,4), winner=00, running=1.
- Assert rst during STEP_P2 → next cycle IDLE, trail_we=0, all outputs at reset values.
